fp_addsub: RTL and testbench
============================

FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 EXP_W, 8, exponent field width (range 5..11).
REQ-002 MAN_W, 23, stored mantissa field width (range 10..52); W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 input_a  input  W  operand A, IEEE-754 layout {sign, exponent, mantissa}.
REQ-006 input_a_stb  input  1  operand A valid.
REQ-007 input_a_ack  output  1  block ready for operand A.
REQ-008 input_b  input  W  operand B.
REQ-009 input_b_stb  input  1  operand B valid.
REQ-010 input_b_ack  output  1  block ready for operand B.
REQ-011 op  input  1  0 = A+B, 1 = A-B; sampled with operand B.
REQ-012 output_z  output  W  result.
REQ-013 output_z_stb  output  1  result valid.
REQ-014 output_z_ack  input  1  consumer accepts result.

Function
REQ-015 Transfer on any port occurs only at a rising edge where its stb and ack are both 1.
REQ-016 States: GET, UNPACK, ALIGN, ADD, NORM, ROUND, PUT_Z; fixed sequence, no skipping.
REQ-017 GET: input_a_ack=1 until A captured and input_b_ack=1 until B captured; A and B may be captured on the same edge or on different edges in either order.
REQ-018 Each ack drops on the edge that captures its operand; GET exits to UNPACK on the edge when both are held.
REQ-019 output_z_stb rises exactly 5 edges after the edge that captures the second operand; special cases use the same latency.
REQ-020 PUT_Z: output_z and output_z_stb held stable until the output transfer edge; then stb=0, state=GET, both acks=1 from that edge.
REQ-021 Operand stb/data changes while not acked are ignored; output_z_ack while stb=0 is ignored.
REQ-022 op=1 inverts B sign in UNPACK; all arithmetic thereafter is addition.
REQ-023 UNPACK: biased exponent 0 = denormal (hidden bit 0, exponent 1-bias); otherwise hidden bit 1.
REQ-024 ALIGN: smaller-magnitude operand right-shifted by exponent difference in one cycle (barrel), with guard, round and sticky bits; shift >= MAN_W+3 leaves only sticky.
REQ-025 ADD: signed-magnitude add/subtract, MAN_W+5 bit datapath including carry.
REQ-026 NORM: one-cycle normalise via leading-zero count; carry-out shifts right 1, exponent +1; left shift limited so exponent does not go below denormal minimum (gradual underflow).
REQ-027 ROUND: round-to-nearest-even; mantissa overflow from rounding increments exponent.
REQ-028 Exponent >= all-ones after rounding -> signed infinity.
REQ-029 Exact zero sum of opposite signs -> +0; (+0)+(+0)=+0; (-0)+(-0)=-0.
REQ-030 Any NaN input, or inf plus inf of opposite effective sign -> canonical quiet NaN: sign 0, exponent all ones, mantissa MSB 1, rest 0.
REQ-031 inf plus finite -> that inf; finite plus zero -> the finite operand unchanged.

Reset
REQ-032 While rst=1: state=GET, A/B held flags cleared, input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0.
REQ-033 Both acks rise on the first rising edge after rst deasserts.
REQ-034 rst asserted in any state aborts the operation immediately; no partial result is ever presented.

Structure
REQ-035 Shared package fp_pkg holds state enum, default EXP_W/MAN_W, and functions producing bias, canonical NaN and infinity patterns from parameters.
REQ-036 Leading-zero count is a separate parametrised sub-module fp_lzc, instantiated once in NORM.
REQ-037 No multicycle paths; one FSM, datapath registers only.

Verification
REQ-038 Default params, op=0, A=3f000000, B=00000000 with stb and output_z_ack held 1 -> output_z=3f000000, stb 5 edges after capture.
REQ-039 A=3e19999a, B=be19999a, op=0 -> 00000000; then A=3f800000, B=3f000000, op=1 -> 3f000000.
REQ-040 A stb 3 cycles before B stb -> input_a_ack drops at A capture, B still acked; result 5 edges after B capture.
REQ-041 7f7fffff+7f7fffff -> 7f800000; 7f800000+ff800000 -> 7fc00000; 00000001+00000001 -> 00000002.
REQ-042 output_z_ack held 0 for 10 cycles -> output_z and stb stable, both acks 0; release -> GET next edge.
REQ-043 EXP_W=5, MAN_W=10: 3c00+3c00 -> 4000; rst pulsed during ALIGN -> all outputs 0 at once, acks 1 on first edge after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract block.
//   - state_t      : sequencer states, visited strictly in declaration order
//   - *_DEFAULT    : default exponent/mantissa field widths (IEEE single)
//   - fp_bias()    : exponent bias for a given exponent width
//   - fp_inf()     : +infinity bit pattern (exponent all ones, mantissa 0)
//   - fp_qnan()    : canonical quiet NaN (sign 0, exponent all ones, mantissa MSB 1)
// The pattern functions return 64-bit values; callers keep the low W bits.
package fp_pkg;

  localparam int EXP_W_DEFAULT = 8;
  localparam int MAN_W_DEFAULT = 23;

  typedef enum logic [2:0] {
    ST_GET,
    ST_UNPACK,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_PUT_Z
  } state_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return ones << man_w;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter.
//   data_i  : WIDTH-bit value to scan from the MSB down
//   count_o : number of zeros above the highest set bit (WIDTH when data_i == 0)
module fp_lzc #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]           data_i,
  output logic [$clog2(WIDTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // NOTE: always_comb gets a default on entry so no path leaves count_o
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_o = CNT_W'(WIDTH);
    // Scanning upward lets the highest set bit be the last (winning) write.
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub.sv
// Sequential IEEE-754 style adder/subtractor with stb/ack handshakes.
//   clk, rst                          : clock, asynchronous active-high reset
//   input_a / _stb / _ack             : operand A handshake
//   input_b / _stb / _ack, op         : operand B handshake; op=1 selects A-B
//   output_z / _stb / _ack            : result handshake
// A fixed GET->UNPACK->ALIGN->ADD->NORM->ROUND->PUT_Z walk gives a constant
// five-edge latency from the second operand capture to output_z_stb.
// Exponents are kept biased internally; a denormal uses biased exponent 1.
module fp_addsub
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEFAULT,
  parameter int MAN_W = MAN_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_W+MAN_W:0]     input_a,
  input  logic                     input_a_stb,
  output logic                     input_a_ack,
  input  logic [EXP_W+MAN_W:0]     input_b,
  input  logic                     input_b_stb,
  output logic                     input_b_ack,
  input  logic                     op,
  output logic [EXP_W+MAN_W:0]     output_z,
  output logic                     output_z_stb,
  input  logic                     output_z_ack
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;   // hidden + mantissa + guard/round/sticky
  localparam int SW  = MAN_W + 5;   // MW plus carry
  localparam int EW  = EXP_W + 1;   // biased exponent plus overflow headroom
  localparam int LZW = $clog2(MW + 1);

  localparam logic [63:0]   INF64   = fp_inf(EXP_W, MAN_W);
  localparam logic [63:0]   QNAN64  = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-2:0]  INF_MAG = INF64[W-2:0];
  localparam logic [W-1:0]  QNAN    = QNAN64[W-1:0];
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  // Control state
  state_t         state_q;
  logic           a_held_q, b_held_q, a_ack_q, b_ack_q, z_stb_q;
  logic [W-1:0]   z_q;

  // Datapath registers
  logic [W-1:0]   a_q, b_q, special_z_q;
  logic           op_q, special_q;
  logic           sign_a_q, sign_b_q, sign_l_q, sign_s_q, sign_z_q;
  logic [EW-1:0]  exp_a_q, exp_b_q, exp_q;
  logic [MAN_W:0] man_a_q, man_b_q;
  logic [MW-1:0]  man_l_q, man_s_q, man_n_q;
  logic [SW-1:0]  sum_q;

  logic a_cap, b_cap;
  assign a_cap = a_ack_q & input_a_stb;
  assign b_cap = b_ack_q & input_b_stb;

  // UNPACK: field split, effective B sign, special-case detection
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             sa, sb, a_nan, b_nan, a_inf, b_inf, special_d;
  logic [W-1:0]     special_z_d;

  always_comb begin
    ea = a_q[W-2:MAN_W];
    eb = b_q[W-2:MAN_W];
    ma = a_q[MAN_W-1:0];
    mb = b_q[MAN_W-1:0];
    sa = a_q[W-1];
    sb = b_q[W-1] ^ op_q;
    a_nan = (&ea) & (|ma);
    b_nan = (&eb) & (|mb);
    a_inf = (&ea) & ~(|ma);
    b_inf = (&eb) & ~(|mb);
    special_d   = 1'b1;
    special_z_d = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) special_z_d = QNAN;
    else if (a_inf)                                      special_z_d = {sa, INF_MAG};
    else if (b_inf)                                      special_z_d = {sb, INF_MAG};
    else                                                 special_d   = 1'b0;
  end

  // ALIGN: order by magnitude, barrel-shift the smaller with sticky collection
  logic            sign_l_d, sign_s_d;
  logic [EW-1:0]   exp_l_d, exp_s_d, diff_d, shamt_d;
  logic [MAN_W:0]  man_l_d, man_s_d;
  logic [2*MW-1:0] ext_d;
  logic [MW-1:0]   man_s_al_d;

  always_comb begin
    if ({exp_a_q, man_a_q} >= {exp_b_q, man_b_q}) begin
      exp_l_d = exp_a_q;  man_l_d = man_a_q;  sign_l_d = sign_a_q;
      exp_s_d = exp_b_q;  man_s_d = man_b_q;  sign_s_d = sign_b_q;
    end else begin
      exp_l_d = exp_b_q;  man_l_d = man_b_q;  sign_l_d = sign_b_q;
      exp_s_d = exp_a_q;  man_s_d = man_a_q;  sign_s_d = sign_a_q;
    end
    diff_d = exp_l_d - exp_s_d;
    // Clamping at MW keeps every shifted-out bit inside the lower half, so
    // the sticky OR still sees them on very large exponent differences.
    shamt_d    = (diff_d > EW'(MW)) ? EW'(MW) : diff_d;
    ext_d      = {man_s_d, 3'b000, {MW{1'b0}}} >> shamt_d;
    man_s_al_d = ext_d[2*MW-1:MW] | {{(MW-1){1'b0}}, |ext_d[MW-1:0]};
  end

  // ADD: larger magnitude is always the minuend, so the result never goes negative
  logic [SW-1:0] sum_d;
  logic          sign_z_d;

  always_comb begin
    if (sign_l_q == sign_s_q) sum_d = {1'b0, man_l_q} + {1'b0, man_s_q};
    else                      sum_d = {1'b0, man_l_q} - {1'b0, man_s_q};
    // Exact cancellation of opposite signs yields +0.
    sign_z_d = (sum_d == '0 && sign_l_q != sign_s_q) ? 1'b0 : sign_l_q;
  end

  // NORM: carry shifts right; otherwise shift left by the leading-zero count,
  // capped so the exponent never drops below the denormal minimum of 1.
  logic [LZW-1:0] lz;
  logic [EW-1:0]  lz_ext, limit_d, shift_d, exp_n_d;
  logic [MW-1:0]  man_n_d;

  fp_lzc #(.WIDTH(MW)) u_lzc (
    .data_i  (sum_q[MW-1:0]),
    .count_o (lz)
  );

  always_comb begin
    lz_ext  = EW'(lz);
    limit_d = exp_q - EW'(1);
    shift_d = '0;
    if (sum_q[SW-1]) begin
      man_n_d = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
      exp_n_d = exp_q + EW'(1);
    end else begin
      shift_d = (lz_ext > limit_d) ? limit_d : lz_ext;
      man_n_d = sum_q[MW-1:0] << shift_d;
      exp_n_d = exp_q - shift_d;
    end
  end

  // ROUND: nearest-even on guard/round/sticky, then pack
  logic             rnd_up;
  logic [MAN_W+1:0] m_r;
  logic [MAN_W:0]   m_f;
  logic [EW-1:0]    exp_r;
  logic [W-1:0]     z_d;

  always_comb begin
    rnd_up = man_n_q[2] & (man_n_q[1] | man_n_q[0] | man_n_q[3]);
    m_r    = {1'b0, man_n_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    if (m_r[MAN_W+1]) begin
      m_f   = m_r[MAN_W+1:1];
      exp_r = exp_q + EW'(1);
    end else begin
      m_f   = m_r[MAN_W:0];
      exp_r = exp_q;
    end
    if (special_q)             z_d = special_z_q;
    else if (exp_r >= EXP_MAX) z_d = {sign_z_q, INF_MAG};
    // Hidden bit clear means the result stayed denormal: exponent field 0.
    else if (m_f[MAN_W])       z_d = {sign_z_q, exp_r[EXP_W-1:0], m_f[MAN_W-1:0]};
    else                       z_d = {sign_z_q, {EXP_W{1'b0}}, m_f[MAN_W-1:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_GET;
      a_held_q <= 1'b0;
      b_held_q <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      z_stb_q  <= 1'b0;
      z_q      <= '0;
    end else begin
      unique case (state_q)
        ST_GET: begin
          if (a_cap) begin
            a_held_q <= 1'b1;
            a_ack_q  <= 1'b0;
          end else if (!a_held_q) begin
            a_ack_q  <= 1'b1;
          end
          if (b_cap) begin
            b_held_q <= 1'b1;
            b_ack_q  <= 1'b0;
          end else if (!b_held_q) begin
            b_ack_q  <= 1'b1;
          end
          if ((a_held_q || a_cap) && (b_held_q || b_cap)) begin
            state_q  <= ST_UNPACK;
            a_held_q <= 1'b0;
            b_held_q <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
          end
        end
        ST_UNPACK: state_q <= ST_ALIGN;
        ST_ALIGN:  state_q <= ST_ADD;
        ST_ADD:    state_q <= ST_NORM;
        ST_NORM:   state_q <= ST_ROUND;
        ST_ROUND: begin
          state_q <= ST_PUT_Z;
          z_q     <= z_d;
          z_stb_q <= 1'b1;
        end
        ST_PUT_Z: begin
          if (output_z_ack) begin
            state_q <= ST_GET;
            z_stb_q <= 1'b0;
            a_ack_q <= 1'b1;
            b_ack_q <= 1'b1;
          end
        end
        default: state_q <= ST_GET;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; every one is written before it
  // is read within a pass, and the control block guarantees no stale result
  // is ever presented.
  always_ff @(posedge clk) begin
    unique case (state_q)
      ST_GET: begin
        if (a_cap) a_q <= input_a;
        if (b_cap) begin
          b_q  <= input_b;
          op_q <= op;
        end
      end
      ST_UNPACK: begin
        sign_a_q    <= sa;
        sign_b_q    <= sb;
        exp_a_q     <= (ea == '0) ? EW'(1) : {1'b0, ea};
        exp_b_q     <= (eb == '0) ? EW'(1) : {1'b0, eb};
        man_a_q     <= {|ea, ma};
        man_b_q     <= {|eb, mb};
        special_q   <= special_d;
        special_z_q <= special_z_d;
      end
      ST_ALIGN: begin
        sign_l_q <= sign_l_d;
        sign_s_q <= sign_s_d;
        exp_q    <= exp_l_d;
        man_l_q  <= {man_l_d, 3'b000};
        man_s_q  <= man_s_al_d;
      end
      ST_ADD: begin
        sum_q    <= sum_d;
        sign_z_q <= sign_z_d;
      end
      ST_NORM: begin
        man_n_q <= man_n_d;
        exp_q   <= exp_n_d;
      end
      default: ;
    endcase
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_fp_addsub.sv
module tb_fp_addsub;

  logic clk;
  logic rst, rst_h;

  // Single-precision instance
  logic [31:0] a, b, z;
  logic        a_stb, a_ack, b_stb, b_ack, op, z_stb, z_ack;

  // Half-precision instance
  logic [15:0] ha, hb, hz;
  logic        ha_stb, ha_ack, hb_stb, hb_ack, hop, hz_stb, hz_ack;

  int passed = 0;
  int total  = 0;
  logic [31:0] sb_q[$];
  logic [15:0] hsb_q[$];

  fp_addsub u_dut (
    .clk (clk), .rst (rst),
    .input_a (a), .input_a_stb (a_stb), .input_a_ack (a_ack),
    .input_b (b), .input_b_stb (b_stb), .input_b_ack (b_ack),
    .op (op),
    .output_z (z), .output_z_stb (z_stb), .output_z_ack (z_ack)
  );

  fp_addsub #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk (clk), .rst (rst_h),
    .input_a (ha), .input_a_stb (ha_stb), .input_a_ack (ha_ack),
    .input_b (hb), .input_b_stb (hb_stb), .input_b_ack (hb_ack),
    .op (hop),
    .output_z (hz), .output_z_stb (hz_stb), .output_z_ack (hz_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present both operands and wait (bounded) until both have been captured.
  task automatic capture_both(output bit ok);
    bit got_a, got_b;
    got_a = 1'b0;
    got_b = 1'b0;
    for (int i = 0; i < 50 && !(got_a && got_b); i++) begin
      bit ca, cb;
      ca = a_ack & a_stb;
      cb = b_ack & b_stb;
      @(posedge clk); #1;
      if (ca) begin got_a = 1'b1; a_stb = 1'b0; end
      if (cb) begin got_b = 1'b1; b_stb = 1'b0; end
    end
    a_stb = 1'b0;
    b_stb = 1'b0;
    ok = got_a && got_b;
  endtask

  // Count edges until output_z_stb rises (bounded at 20).
  task automatic wait_z(output int lat);
    lat = 0;
    while (!z_stb && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_txn(input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic op_v, output int lat);
    bit ok;
    a = a_v; b = b_v; op = op_v;
    a_stb = 1'b1; b_stb = 1'b1;
    capture_both(ok);
    if (!ok) lat = 99;
    else     wait_z(lat);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a_ack, b_ack, z_stb} !== 3'b000)
      $display("FAIL reset_ctrl: acks/stb=%b want 000", {a_ack, b_ack, z_stb});
    else passed++;
    total++;
    if (z !== 32'h0) $display("FAIL reset_z: got %h want 00000000", z);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({a_ack, b_ack} !== 2'b11)
      $display("FAIL reset_release_acks: got %b want 11", {a_ack, b_ack});
    else passed++;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] z;
  } vec_t;

  task automatic test_vectors;
    vec_t vecs[15];
    int lat;
    logic [31:0] exp_v;
    vecs[0]  = '{32'h3f000000, 32'h00000000, 1'b0, 32'h3f000000};
    vecs[1]  = '{32'h3e19999a, 32'hbe19999a, 1'b0, 32'h00000000};
    vecs[2]  = '{32'h3f800000, 32'h3f000000, 1'b1, 32'h3f000000};
    vecs[3]  = '{32'h7f7fffff, 32'h7f7fffff, 1'b0, 32'h7f800000};
    vecs[4]  = '{32'h7f800000, 32'hff800000, 1'b0, 32'h7fc00000};
    vecs[5]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002};
    vecs[6]  = '{32'h7f800000, 32'h3f800000, 1'b0, 32'h7f800000};
    vecs[7]  = '{32'h7fc00001, 32'h3f800000, 1'b0, 32'h7fc00000};
    vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    vecs[9]  = '{32'h3f800000, 32'h33800000, 1'b0, 32'h3f800000};
    vecs[10] = '{32'h3f800001, 32'h33800000, 1'b0, 32'h3f800002};
    vecs[11] = '{32'h3f800000, 32'h3f7fffff, 1'b1, 32'h33800000};
    vecs[12] = '{32'h3f800000, 32'hbf800000, 1'b1, 32'h40000000};
    vecs[13] = '{32'hff800000, 32'hff800000, 1'b1, 32'h7fc00000};
    vecs[14] = '{32'h40400000, 32'hc0000000, 1'b0, 32'h3f800000};
    z_ack = 1'b1;
    foreach (vecs[i]) begin
      sb_q.push_back(vecs[i].z);
      do_txn(vecs[i].a, vecs[i].b, vecs[i].op, lat);
      exp_v = sb_q.pop_front();
      total++;
      if (lat !== 5) $display("FAIL vec%0d_latency: got %0d want 5", i, lat);
      else passed++;
      total++;
      if (z !== exp_v)
        $display("FAIL vec%0d_result: %h %s %h got %h want %h",
                 i, vecs[i].a, vecs[i].op ? "-" : "+", vecs[i].b, z, exp_v);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({z_stb, a_ack, b_ack} !== 3'b011)
        $display("FAIL vec%0d_handoff: stb/acks=%b want 011", i, {z_stb, a_ack, b_ack});
      else passed++;
    end
  endtask

  task automatic test_a_before_b;
    int lat;
    bit got_b;
    logic [31:0] exp_v;
    z_ack = 1'b1;
    sb_q.push_back(32'h40400000);
    a = 32'h3fc00000; a_stb = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({a_ack, b_ack} !== 2'b01)
      $display("FAIL a_first_acks: got %b want 01", {a_ack, b_ack});
    else passed++;
    // Junk on A while not acked must be ignored.
    a = 32'hdeadbeef;
    repeat (2) @(posedge clk);
    #1;
    a_stb = 1'b0;
    total++;
    if ({a_ack, b_ack, z_stb} !== 3'b010)
      $display("FAIL a_first_wait: acks/stb=%b want 010", {a_ack, b_ack, z_stb});
    else passed++;
    b = 32'h3fc00000; op = 1'b0; b_stb = 1'b1;
    got_b = 1'b0;
    for (int i = 0; i < 20 && !got_b; i++) begin
      bit cb;
      cb = b_ack & b_stb;
      @(posedge clk); #1;
      if (cb) got_b = 1'b1;
    end
    b_stb = 1'b0;
    if (got_b) wait_z(lat);
    else       lat = 99;
    exp_v = sb_q.pop_front();
    total++;
    if (lat !== 5) $display("FAIL a_first_latency: got %0d want 5", lat);
    else passed++;
    total++;
    if (z !== exp_v) $display("FAIL a_first_result: got %h want %h", z, exp_v);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    bit bad;
    logic [31:0] exp_v;
    z_ack = 1'b0;
    sb_q.push_back(32'h40000000);
    do_txn(32'h3f800000, 32'h3f800000, 1'b0, lat);
    exp_v = sb_q.pop_front();
    total++;
    if (z !== exp_v || lat !== 5)
      $display("FAIL bp_result: got %h lat %0d want %h lat 5", z, lat, exp_v);
    else passed++;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (z !== exp_v || z_stb !== 1'b1 || a_ack !== 1'b0 || b_ack !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL bp_hold: z=%h stb=%b acks=%b want %h 1 00", z, z_stb, {a_ack, b_ack}, exp_v);
    else passed++;
    z_ack = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({z_stb, a_ack, b_ack} !== 3'b011)
      $display("FAIL bp_release: stb/acks=%b want 011", {z_stb, a_ack, b_ack});
    else passed++;
  endtask

  task automatic h_capture(output bit ok);
    bit got_a, got_b;
    got_a = 1'b0;
    got_b = 1'b0;
    for (int i = 0; i < 50 && !(got_a && got_b); i++) begin
      bit ca, cb;
      ca = ha_ack & ha_stb;
      cb = hb_ack & hb_stb;
      @(posedge clk); #1;
      if (ca) begin got_a = 1'b1; ha_stb = 1'b0; end
      if (cb) begin got_b = 1'b1; hb_stb = 1'b0; end
    end
    ha_stb = 1'b0;
    hb_stb = 1'b0;
    ok = got_a && got_b;
  endtask

  task automatic test_half;
    bit ok, bad;
    int lat;
    logic [15:0] exp_v;
    hz_ack = 1'b1;
    @(negedge clk);
    rst_h = 1'b0;
    @(posedge clk); #1;
    // 1.0 + 1.0 and 1.0 - 0.5
    for (int k = 0; k < 2; k++) begin
      hsb_q.push_back(k == 0 ? 16'h4000 : 16'h3800);
      ha = 16'h3c00;
      hb = (k == 0) ? 16'h3c00 : 16'h3800;
      hop = (k == 1);
      ha_stb = 1'b1; hb_stb = 1'b1;
      h_capture(ok);
      lat = 0;
      while (ok && !hz_stb && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      exp_v = hsb_q.pop_front();
      total++;
      if (!ok || lat !== 5 || hz !== exp_v)
        $display("FAIL half%0d: got %h lat %0d want %h lat 5", k, hz, lat, exp_v);
      else passed++;
      @(posedge clk); #1;
    end
    // Abort during ALIGN: capture edge enters UNPACK, one more edge enters ALIGN.
    ha = 16'h3c00; hb = 16'h3c00; hop = 1'b0;
    ha_stb = 1'b1; hb_stb = 1'b1;
    h_capture(ok);
    @(posedge clk); #1;
    rst_h = 1'b1;
    #1;
    total++;
    if (!ok || {hz, hz_stb, ha_ack, hb_ack} !== 19'h0)
      $display("FAIL half_abort: z=%h stb=%b acks=%b want 0000 0 00", hz, hz_stb, {ha_ack, hb_ack});
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_h = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({ha_ack, hb_ack} !== 2'b11)
      $display("FAIL half_release_acks: got %b want 11", {ha_ack, hb_ack});
    else passed++;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (hz_stb !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL half_no_partial: stb rose after abort, want 0");
    else passed++;
  endtask

  initial begin
    rst = 1'b1; rst_h = 1'b1;
    a = '0; b = '0; op = 1'b0; a_stb = 1'b0; b_stb = 1'b0; z_ack = 1'b1;
    ha = '0; hb = '0; hop = 1'b0; ha_stb = 1'b0; hb_stb = 1'b0; hz_ack = 1'b1;
    test_reset;
    test_vectors;
    test_a_before_b;
    test_backpressure;
    test_half;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
